// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit midpoint qualification, 8 data bits LSB first, one stop bit.
// Emits a one-cycle valid or frame_err pulse per frame and holds the last good byte on data.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [7:0]  shreg, shreg_nx;
    logic [7:0]  data_nx;
    logic        valid_nx, frame_err_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            data      <= data_nx;
            valid     <= valid_nx;
            frame_err <= frame_err_nx;
            busy      <= (state_nx != IDLE);
        end
    end

    // Counter restarts on every sample point, so it never exceeds CLKS_PER_BIT-1.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + 16'd1;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        data_nx      = data;
        valid_nx     = 1'b0;
        frame_err_nx = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx) state_nx = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nx = '0;
                    if (rx) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nx     = '0;
                    shreg_nx   = {rx, shreg[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nx = '0;
                    if (rx) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nx = '0;
                if (rx) state_nx = IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks/bit: table of frames plus glitch, break and reset sequences,
// with a pulse scoreboard checking byte, pulse kind and exact cycle.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int LAT     = CPB / 2 + 9 * CPB;  // start detect to stop sample: 152

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } sb_item_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    sb_item_t   sb[$];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every pulse must match the head of the scoreboard in kind, byte and cycle.
    always @(negedge clk) begin
        if (reset && (valid || frame_err)) begin
            n_assert++;
            if (valid && frame_err) begin
                n_fail++;
                $display("FAIL pulse_excl: valid and frame_err both high at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%0h at cycle %0d",
                         valid, frame_err, data, cyc);
            end else begin
                sb_item_t e;
                e = sb.pop_front();
                if (frame_err !== e.is_err || data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got err=%0b data=%0h cyc=%0d expected err=%0b data=%0h cyc=%0d",
                             frame_err, data, cyc, e.is_err, e.data, e.cyc);
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; start bit is sampled on the next edge (k).
    task automatic expect_pulse(input logic is_err, input logic [7:0] d);
        sb_item_t e;
        e.is_err = is_err;
        e.data   = d;
        e.cyc    = cyc + 1 + LAT;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic exp_err, input logic [7:0] exp_data);
        expect_pulse(exp_err, exp_data);
        drive_bit(1'b0);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        check("busy_after_stop", busy, stop ? 0 : 1);
        rx = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 3,  1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 0,  1'b0, 8'h3C};
        vecs[2] = '{8'hC3, 1'b0, 20, 1'b1, 8'h3C};  // bad stop: data keeps 0x3C
        vecs[3] = '{8'h00, 1'b1, 0,  1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 4,  1'b0, 8'hFF};  // back-to-back with 0x00
        vecs[5] = '{8'h12, 1'b1, 2,  1'b0, 8'h12};

        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        #21 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].exp_err, vecs[i].exp_data);
            if (!vecs[i].exp_err) last_data = vecs[i].exp_data;
            repeat (vecs[i].gap) @(posedge clk);
            #1;
        end

        // 5-cycle glitch: start detected at k, rejected at k+8.
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("glitch_busy_k7", busy, 1);
        @(posedge clk);
        #1 check("glitch_busy_k8", busy, 0);
        check("glitch_data", data, last_data);
        repeat (4) @(posedge clk);
        #1;

        // Long break: one frame_err, then a clean frame.
        expect_pulse(1'b1, last_data);
        rx = 1'b0;
        repeat (40 * CPB) @(posedge clk);
        #1 check("break_busy", busy, 1);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1 check("break_idle", busy, 0);
        send_frame(8'h81, 1'b1, 1'b0, 8'h81);
        last_data = 8'h81;
        repeat (5) @(posedge clk);
        #1 check("pre_reset_data", data, 8'h81);

        // Reset mid data bit 4: partial byte discarded, outputs cleared without a clock edge.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_data", data, 8'h00);
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_ferr", frame_err, 0);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        last_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b1, 1'b0, 8'h5A);
        last_data = 8'h5A;

        repeat (20) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("final_data", data, last_data);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
- REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
- REQ-003 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset.
- REQ-004 The block SHALL have port rx, input, 1 bit, meaning serial line already synchronized to clk by the upstream synchronizer stage, idle high.
- REQ-005 The block SHALL have port data, output, 8 bits, meaning the last correctly received byte.
- REQ-006 The block SHALL have port valid, output, 1 bit, meaning a one-cycle pulse marking a new byte on data.
- REQ-007 The block SHALL have port frame_err, output, 1 bit, meaning a one-cycle pulse marking a stop bit sampled low.
- REQ-008 The block SHALL have port busy, output, 1 bit, meaning high in any state other than IDLE.

Function
- REQ-009 The block SHALL receive 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- REQ-010 The block SHALL implement states IDLE, START, DATA, STOP and BREAK, with a 16-bit cycle counter and a 3-bit bit index.
- REQ-011 In IDLE, rx=0 sampled at edge k SHALL move the FSM to START and clear the counter.
- REQ-012 In START, rx SHALL be sampled at edge k+HALF, where HALF = CLKS_PER_BIT/2 with integer truncation.
- REQ-013 At that START sample, rx=1 SHALL return the FSM to IDLE with no output pulse (glitch rejection), and rx=0 SHALL move it to DATA with the counter cleared.
- REQ-014 In DATA, data bit i (i=0..7) SHALL be sampled at edge k+HALF+(i+1)*CLKS_PER_BIT into an internal shift register.
- REQ-015 After bit 7 is sampled, the FSM SHALL move to STOP.
- REQ-016 In STOP, rx SHALL be sampled at edge k+HALF+9*CLKS_PER_BIT.
- REQ-017 A STOP sample of rx=1 SHALL update data with the shift register and assert valid on that same edge for exactly one cycle, then move to IDLE.
- REQ-018 A STOP sample of rx=0 SHALL assert frame_err for exactly one cycle, leave data unchanged, and move to BREAK.
- REQ-019 In BREAK, the FSM SHALL stay until rx=1 is sampled, then move to IDLE with no further pulses regardless of low duration.
- REQ-020 valid and frame_err SHALL never be high in the same cycle.
- REQ-021 data SHALL hold its value between valid pulses; it is not affected by rejected starts or framing errors.
- REQ-022 A new start bit SHALL be detected on the first edge after returning to IDLE, supporting back-to-back frames with zero idle gap beyond the stop bit's second half.
- REQ-023 The counter SHALL never wrap: it is cleared on every state transition and at each bit sample.
- REQ-024 Outputs SHALL be registered with no combinational path from rx.

Reset
- REQ-025 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, bit index 0, shift register 0x00, data 0x00, valid 0, frame_err 0, busy 0.
- REQ-026 Reset asserted mid-frame SHALL discard the partial byte.
- REQ-027 After reset deasserts, the block SHALL require rx=0 sampled in IDLE to begin a frame; a line already low at release SHALL be treated as a start.

Verification (bench uses CLKS_PER_BIT=16, HALF=8)
- REQ-028 Frame 0xA5 with start detected at edge k SHALL produce data=0xA5 and valid=1 at edge k+152 only, with busy high from k to k+152.
- REQ-029 A 5-cycle low glitch on idle rx SHALL return the FSM to IDLE at edge k+8 with no valid or frame_err pulse and data unchanged.
- REQ-030 Frame 0x3C followed by a frame with stop bit 0 SHALL produce one frame_err pulse at edge k+152 of the second frame, with data remaining 0x3C.
- REQ-031 Back-to-back frames 0x00 then 0xFF with no idle gap SHALL produce two valid pulses exactly 160 cycles apart, with data 0x00 then 0xFF.
- REQ-032 rx held low for 40 bit periods then released SHALL produce exactly one frame_err pulse, after which a frame 0x81 SHALL be received correctly.
- REQ-033 Reset pulsed low during data bit 4 SHALL clear all outputs asynchronously, and a following frame 0x5A SHALL be received correctly.
